// File: rtl/pipe_stage_ctrl.sv
// Four-stage (decode/exec/mem/wb) occupancy and flush tracker for an in-order pipeline.
// Optional performance counters are compiled in when PIPE_PERF_CNT_EN is defined.
module pipe_stage_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        halt_decode_i,
  input  logic        halt_exec_i,
  input  logic        halt_mem_i,
  input  logic        halt_reg_write_i,
  output logic        instr_ready_o,
  output logic        dec_valid_o,
  output logic        exec_valid_o,
  output logic        mem_valid_o,
  output logic        wb_valid_o,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  output logic [31:0] exec_pc_o,
  output logic [31:0] mem_pc_o,
  output logic [31:0] wb_pc_o,
  output logic        retire_o,
  output logic        flush_active_o,
  output logic [31:0] retire_cnt_o,
  output logic [15:0] bubble_cnt_o
);

  typedef enum logic {IDLE, FLUSH} flush_state_e;

  flush_state_e state_q, state_d;
  logic dec_pf, exec_pf, mem_pf, wb_pf;
  logic halt_any;
  logic transfer;

  assign halt_any      = halt_decode_i | halt_exec_i | halt_mem_i | halt_reg_write_i;
  assign instr_ready_o = ~stall_i & ~halt_decode_i & ~reset_i;
  assign transfer      = instr_valid_i & instr_ready_o;
  assign retire_o      = wb_valid_o & ~halt_reg_write_i & ~reset_i;

  // A kill overrides a stall; a killed decode entry keeps its pc/instr.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dec_valid_o <= 1'b0;
      dec_instr_o <= 32'd0;
      dec_pc_o    <= 32'd0;
      dec_pf      <= 1'b0;
    end else if (halt_decode_i) begin
      dec_valid_o <= 1'b0;
    end else if (!stall_i) begin
      dec_valid_o <= transfer;
      dec_instr_o <= instr_i;
      dec_pc_o    <= pc_i;
      dec_pf      <= flush_active_o | halt_any;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exec_valid_o <= 1'b0;
      mem_valid_o  <= 1'b0;
      wb_valid_o   <= 1'b0;
      exec_pc_o    <= 32'd0;
      mem_pc_o     <= 32'd0;
      wb_pc_o      <= 32'd0;
      exec_pf      <= 1'b0;
      mem_pf       <= 1'b0;
      wb_pf        <= 1'b0;
    end else begin
      exec_valid_o <= dec_valid_o & ~halt_decode_i & ~stall_i;
      mem_valid_o  <= exec_valid_o & ~halt_exec_i;
      wb_valid_o   <= mem_valid_o & ~halt_mem_i;
      exec_pc_o    <= dec_pc_o;
      mem_pc_o     <= exec_pc_o;
      wb_pc_o      <= mem_pc_o;
      exec_pf      <= dec_pf;
      mem_pf       <= exec_pf;
      wb_pf        <= mem_pf;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // The redirect ends once the first instruction fetched after it retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (halt_any) state_d = FLUSH;
      FLUSH:   if (!halt_any && retire_o && wb_pf) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_active_o = (state_q == FLUSH);
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] retire_cnt_q;
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retire_cnt_q <= 32'd0;
      bubble_cnt_q <= 16'd0;
    end else begin
      if (retire_o) retire_cnt_q <= retire_cnt_q + 32'd1;
      if (!wb_valid_o && bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign retire_cnt_o = 32'd0;
  assign bubble_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: slot-array reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipe_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic [31:0] pc_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        halt_decode_i = 1'b0;
  logic        halt_exec_i = 1'b0;
  logic        halt_mem_i = 1'b0;
  logic        halt_reg_write_i = 1'b0;
  logic        instr_ready_o;
  logic        dec_valid_o, exec_valid_o, mem_valid_o, wb_valid_o;
  logic [31:0] dec_instr_o, dec_pc_o, exec_pc_o, mem_pc_o, wb_pc_o;
  logic        retire_o, flush_active_o;
  logic [31:0] retire_cnt_o;
  logic [15:0] bubble_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .pc_i(pc_i), .stall_i(stall_i), .halt_decode_i(halt_decode_i), .halt_exec_i(halt_exec_i),
    .halt_mem_i(halt_mem_i), .halt_reg_write_i(halt_reg_write_i), .instr_ready_o(instr_ready_o),
    .dec_valid_o(dec_valid_o), .exec_valid_o(exec_valid_o), .mem_valid_o(mem_valid_o),
    .wb_valid_o(wb_valid_o), .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
    .exec_pc_o(exec_pc_o), .mem_pc_o(mem_pc_o), .wb_pc_o(wb_pc_o), .retire_o(retire_o),
    .flush_active_o(flush_active_o), .retire_cnt_o(retire_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: slot 0 = decode .. slot 3 = writeback.
  bit          model_ok = 1'b0;
  logic        m_valid [4];
  logic [31:0] m_pc [4];
  logic        m_pf [4];
  logic [31:0] m_instr;
  logic        m_flush;
  logic [31:0] m_retires;
  int          m_bubbles;

  always @(posedge clk_i) begin
    logic [3:0] halt;
    logic       retire_now;
    logic       flush_next;
    halt = {halt_reg_write_i, halt_mem_i, halt_exec_i, halt_decode_i};
    if (reset_i) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0;
        m_pc[i]    = 32'd0;
        m_pf[i]    = 1'b0;
      end
      m_instr   = 32'd0;
      m_flush   = 1'b0;
      m_retires = 32'd0;
      m_bubbles = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      retire_now = m_valid[3] && !halt_reg_write_i;
      if (retire_now) m_retires = m_retires + 32'd1;
      if (!m_valid[3] && m_bubbles < 65535) m_bubbles++;
      if (|halt) flush_next = 1'b1;
      else if (retire_now && m_pf[3]) flush_next = 1'b0;
      else flush_next = m_flush;
      for (int i = 3; i >= 1; i--) begin
        m_valid[i] = m_valid[i-1] && !halt[i-1] && !(i == 1 && stall_i);
        m_pc[i]    = m_pc[i-1];
        m_pf[i]    = m_pf[i-1];
      end
      if (halt_decode_i) m_valid[0] = 1'b0;
      else if (!stall_i) begin
        m_valid[0] = instr_valid_i;
        m_pc[0]    = pc_i;
        m_instr    = instr_i;
        m_pf[0]    = m_flush || (|halt);
      end
      m_flush = flush_next;
    end
  end

  always @(negedge clk_i) begin
    logic [31:0] exp_ret, exp_bub;
    #1;
    if (model_ok) begin
`ifdef PIPE_PERF_CNT_EN
      exp_ret = m_retires;
      exp_bub = 32'(m_bubbles);
`else
      exp_ret = 32'd0;
      exp_bub = 32'd0;
`endif
      checkOutput("instr_ready", 32'(instr_ready_o), 32'(!stall_i && !halt_decode_i && !reset_i));
      checkOutput("retire", 32'(retire_o), 32'(m_valid[3] && !halt_reg_write_i && !reset_i));
      checkOutput("dec_valid", 32'(dec_valid_o), 32'(m_valid[0]));
      checkOutput("exec_valid", 32'(exec_valid_o), 32'(m_valid[1]));
      checkOutput("mem_valid", 32'(mem_valid_o), 32'(m_valid[2]));
      checkOutput("wb_valid", 32'(wb_valid_o), 32'(m_valid[3]));
      checkOutput("dec_instr", dec_instr_o, m_instr);
      checkOutput("dec_pc", dec_pc_o, m_pc[0]);
      checkOutput("exec_pc", exec_pc_o, m_pc[1]);
      checkOutput("mem_pc", mem_pc_o, m_pc[2]);
      checkOutput("wb_pc", wb_pc_o, m_pc[3]);
      checkOutput("flush_active", 32'(flush_active_o), 32'(m_flush));
      checkOutput("retire_cnt", retire_cnt_o, exp_ret);
      checkOutput("bubble_cnt", 32'(bubble_cnt_o), exp_bub);
    end
  end

  // Drives one cycle of inputs at the falling edge and returns once outputs have settled.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic st,
                               input logic hd, input logic he, input logic hm,
                               input logic hrw, input logic rst);
    @(negedge clk_i);
    instr_valid_i    = v;
    pc_i             = pc;
    instr_i          = {pc[15:0], 16'h0013};
    stall_i          = st;
    halt_decode_i    = hd;
    halt_exec_i      = he;
    halt_mem_i       = hm;
    halt_reg_write_i = hrw;
    reset_i          = rst;
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_bub10, exp_ret3;
`ifdef PIPE_PERF_CNT_EN
    exp_bub10 = 32'd10;
    exp_ret3  = 32'd3;
`else
    exp_bub10 = 32'd0;
    exp_ret3  = 32'd0;
`endif

    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("lit_reset_ready", 32'(instr_ready_o), 32'd0);
    checkOutput("lit_reset_dec_valid", 32'(dec_valid_o), 32'd0);
    checkOutput("lit_reset_flush", 32'(flush_active_o), 32'd0);
    for (int i = 0; i < 10; i++) idle();
    idle();
    checkOutput("lit_bubble_10", 32'(bubble_cnt_o), exp_bub10);

    // Back-to-back fetches retire four cycles after acceptance.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'(k * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_b2b_ready", 32'(instr_ready_o), 32'd1);
      checkOutput("lit_b2b_no_retire", 32'(retire_o), 32'd0);
      if (k >= 1) checkOutput("lit_b2b_dec_pc", dec_pc_o, 32'((k - 1) * 4));
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      checkOutput("lit_b2b_retire", 32'(retire_o), 32'd1);
      checkOutput("lit_b2b_wb_pc", wb_pc_o, 32'(k * 4));
      if (k == 3) checkOutput("lit_retire_cnt_3", retire_cnt_o, exp_ret3);
    end
    idle();
    checkOutput("lit_b2b_drained", 32'(retire_o), 32'd0);
    idle();

    // Stall holds decode and bubbles exec for two cycles.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_stall_dec_pc", dec_pc_o, 32'h10);
    checkOutput("lit_stall_ready", 32'(instr_ready_o), 32'd0);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_stall_dec_pc2", dec_pc_o, 32'h10);
    checkOutput("lit_stall_exec0", 32'(exec_valid_o), 32'd0);
    idle();
    checkOutput("lit_stall_exec0b", 32'(exec_valid_o), 32'd0);
    checkOutput("lit_stall_dec_hold", 32'(dec_valid_o), 32'd1);
    idle();
    checkOutput("lit_stall_exec_go", 32'(exec_valid_o), 32'd1);
    checkOutput("lit_stall_exec_pc", exec_pc_o, 32'h10);
    for (int i = 0; i < 5; i++) idle();

    // Kill in exec and decode, then redirect to 0x80.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_kill_exec_pc", exec_pc_o, 32'h20);
    checkOutput("lit_kill_dec_pc", dec_pc_o, 32'h24);
    checkOutput("lit_kill_flush_pre", 32'(flush_active_o), 32'd0);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_kill_flush_on", 32'(flush_active_o), 32'd1);
    checkOutput("lit_kill_dec_dead", 32'(dec_valid_o), 32'd0);
    checkOutput("lit_kill_mem_dead", 32'(mem_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("lit_kill_no_retire", 32'(retire_o), 32'd0);
    end
    idle();
    checkOutput("lit_redirect_retire", 32'(retire_o), 32'd1);
    checkOutput("lit_redirect_wb_pc", wb_pc_o, 32'h80);
    checkOutput("lit_redirect_flush", 32'(flush_active_o), 32'd1);
    idle();
    checkOutput("lit_redirect_flush_off", 32'(flush_active_o), 32'd0);

    // Kill beats stall in decode.
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_ks_dec_pc", dec_pc_o, 32'h30);
    applyStimulus(1'b1, 32'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lit_ks_dec_dead", 32'(dec_valid_o), 32'd0);
    checkOutput("lit_ks_dec_pc_kept", dec_pc_o, 32'h30);
    checkOutput("lit_ks_exec_dead", 32'(exec_valid_o), 32'd0);
    for (int i = 0; i < 5; i++) idle();
    checkOutput("lit_ks_flush_off", 32'(flush_active_o), 32'd0);

    // Reset with three entries in flight.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("lit_rst_mem_pc", mem_pc_o, 32'h40);
    checkOutput("lit_rst_ready", 32'(instr_ready_o), 32'd0);
    idle();
    checkOutput("lit_rst_dec", 32'(dec_valid_o), 32'd0);
    checkOutput("lit_rst_exec", 32'(exec_valid_o), 32'd0);
    checkOutput("lit_rst_mem", 32'(mem_valid_o), 32'd0);
    checkOutput("lit_rst_mem_pc0", mem_pc_o, 32'd0);
    checkOutput("lit_rst_bubble0", 32'(bubble_cnt_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      checkOutput("lit_rst_no_retire", 32'(retire_o), 32'd0);
    end

    // Mixed stall/kill pattern, checked by the model.
    for (int i = 0; i < 60; i++)
      applyStimulus(i % 5 != 4, 32'h100 + 32'(i * 4), i % 9 == 2, i % 13 == 5,
                    i % 11 == 7, i % 17 == 3, i % 19 == 8, 1'b0);
    for (int i = 0; i < 8; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
